// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_seq_pkg : shared state, opcode and funct3 encodings for mem_port_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    DATA   = 3'd3,
    COMMIT = 3'd4
  } seq_state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/mem_port_sequencer_lsu_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_align : byte-lane strobes, store replication, load extraction/extension
// Rev 1.0
// ---------------------------------------------------------------------------
module lsu_align
  import mem_seq_pkg::*;
(
  input  logic [2:0]  fn3,
  input  logic [1:0]  offset,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = load_word[7:0];
    w_half    = offset[1] ? load_word[31:16] : load_word[15:0];
    wstrb     = 4'b0000;
    wdata     = store_data;
    load_data = load_word;
    misalign  = 1'b0;

    case (offset)
      2'd1:    w_byte = load_word[15:8];
      2'd2:    w_byte = load_word[23:16];
      2'd3:    w_byte = load_word[31:24];
      default: w_byte = load_word[7:0];
    endcase

    case (fn3)
      F3_B, F3_BU: begin
        wstrb     = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = fn3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      F3_H, F3_HU: begin
        wstrb     = 4'b0011 << offset;
        wdata     = {2{store_data[15:0]}};
        load_data = fn3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        misalign  = offset[0];
      end
      F3_W: begin
        wstrb    = 4'b1111;
        misalign = (offset != 2'd0);
      end
      default: misalign = 1'b1;
    endcase

    // Loads never strobe; a rejected access must not touch memory either.
    if (!is_store || misalign) begin
      wstrb = 4'b0000;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_sequencer : fetch/exec/data/commit sequencer sharing one memory port
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_port_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] RESET_PC_NOP = NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] pc_addr,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  input  logic [2:0]  fn3,
  input  logic [6:0]  opcode,
  output logic [31:0] instruction,
  output logic [31:0] mem_out,
  output logic        core_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [31:0] instret
);

  seq_state_e  r_state;
  seq_state_e  w_next;
  logic [31:0] r_instr;
  logic [31:0] r_mem_out;
  logic        r_misalign_err;
  logic        r_bus_err;
  logic [31:0] r_instret;
  logic [31:0] r_tmo_cnt;

  logic        w_fetch_misalign;
  logic        w_is_load;
  logic        w_is_store;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic        w_lsu_misalign;
  logic        w_req;
  logic        w_timeout;

  assign w_fetch_misalign = |pc_addr[1:0];
  assign w_is_load        = (opcode == OP_LOAD);
  assign w_is_store       = (opcode == OP_STORE);

  lsu_align u_lsu_align (
    .fn3        (fn3),
    .offset     (alu_out[1:0]),
    .is_store   (w_is_store),
    .store_data (rs2_data),
    .load_word  (mem_rdata),
    .wstrb      (w_strb),
    .wdata      (w_wdata),
    .load_data  (w_load_data),
    .misalign   (w_lsu_misalign)
  );

  assign w_req = ((r_state == FETCH) && !w_fetch_misalign) ||
                 ((r_state == DATA)  && !w_lsu_misalign);

  // Fires on the last waiting cycle, so mem_req stays high exactly TIMEOUT cycles.
  assign w_timeout = w_req && !mem_ready && ((r_tmo_cnt + 32'd1) >= TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_req   = w_req;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'b0000;
    core_en   = 1'b0;
    case (r_state)
      IDLE: begin
        if (run) w_next = FETCH;
      end
      FETCH: begin
        mem_addr = {pc_addr[31:2], 2'b00};
        if (w_fetch_misalign || mem_ready || w_timeout) w_next = EXEC;
      end
      EXEC: begin
        w_next = (w_is_load || w_is_store) ? DATA : COMMIT;
      end
      DATA: begin
        mem_addr  = {alu_out[31:2], 2'b00};
        mem_we    = w_is_store && !w_lsu_misalign;
        mem_wstrb = w_strb;
        mem_wdata = w_is_store ? w_wdata : 32'h0;
        if (w_lsu_misalign || mem_ready || w_timeout) w_next = COMMIT;
      end
      COMMIT: begin
        core_en = 1'b1;
        w_next  = run ? FETCH : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr        <= RESET_PC_NOP;
      r_mem_out      <= 32'h0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
      r_instret      <= 32'h0;
      r_tmo_cnt      <= 32'h0;
    end else begin
      if (w_next != r_state) begin
        r_tmo_cnt <= 32'h0;
      end else if (w_req && !mem_ready) begin
        r_tmo_cnt <= r_tmo_cnt + 32'd1;
      end

      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end

      case (r_state)
        FETCH: begin
          if (w_fetch_misalign) begin
            r_misalign_err <= 1'b1;
            r_instr        <= RESET_PC_NOP;
          end else if (mem_ready) begin
            r_instr <= mem_rdata;
          end else if (w_timeout) begin
            r_instr <= RESET_PC_NOP;
          end
        end
        DATA: begin
          if (w_lsu_misalign) begin
            r_misalign_err <= 1'b1;
            r_mem_out      <= 32'h0;
          end else if (w_is_load && mem_ready) begin
            r_mem_out <= w_load_data;
          end else if (w_is_load && w_timeout) begin
            r_mem_out <= 32'h0;
          end
        end
        COMMIT: begin
          r_instret <= r_instret + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign instruction  = r_instr;
  assign mem_out      = r_mem_out;
  assign misalign_err = r_misalign_err;
  assign bus_err      = r_bus_err;
  assign instret      = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_sequencer : directed bench with a tiny reactive memory model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] pc_addr;
  logic [31:0] alu_out;
  logic [31:0] rs2_data;
  logic [2:0]  fn3;
  logic [6:0]  opcode;
  logic [31:0] instruction;
  logic [31:0] mem_out;
  logic        core_en;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        misalign_err;
  logic        bus_err;
  logic [31:0] instret;

  logic        zero_wait;
  logic        force_ready;
  logic [31:0] fetch_word;
  logic [31:0] load_word;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mem_ready = force_ready | (mem_req & zero_wait);
  assign mem_rdata = (mem_addr == {pc_addr[31:2], 2'b00}) ? fetch_word : load_word;

  mem_port_sequencer #(.TIMEOUT(4), .RESET_PC_NOP(32'h0000_0013)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .pc_addr      (pc_addr),
    .alu_out      (alu_out),
    .rs2_data     (rs2_data),
    .fn3          (fn3),
    .opcode       (opcode),
    .instruction  (instruction),
    .mem_out      (mem_out),
    .core_en      (core_en),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .instret      (instret)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; pc_addr = 32'h0; alu_out = 32'h0; rs2_data = 32'h0;
    fn3 = 3'b000; opcode = 7'h13; zero_wait = 1'b1; force_ready = 1'b0;
    fetch_word = 32'h0050_0093; load_word = 32'h0;
    repeat (2) @(negedge clk);

    check("rst_req", mem_req, 0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_core_en", core_en, 0);
    check("rst_instret", instret, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_mem_out", mem_out, 0);
    check("rst_errs", {misalign_err, bus_err}, 0);
    reset = 1'b0;

    // ADDI, zero-wait: FETCH, EXEC, COMMIT
    run = 1'b1;
    step();
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 32'h0);
    check("t1_we", mem_we, 0);
    step();
    check("t1_instr", instruction, 32'h0050_0093);
    check("t1_exec_req", mem_req, 0);
    check("t1_exec_core_en", core_en, 0);
    run = 1'b0;
    step();
    check("t1_core_en", core_en, 1);
    check("t1_we_commit", mem_we, 0);
    step();
    check("t1_core_en_drop", core_en, 0);
    check("t1_instret", instret, 1);
    check("t1_idle_req", mem_req, 0);

    // SB at 0x1002
    pc_addr = 32'h4; fetch_word = 32'h0020_8123; opcode = 7'b0100011; fn3 = 3'b000;
    alu_out = 32'h0000_1002; rs2_data = 32'hAABB_CCDD; run = 1'b1;
    step();
    check("t2_fetch_addr", mem_addr, 32'h4);
    step();
    check("t2_exec_req", mem_req, 0);
    run = 1'b0;
    step();
    check("t2_req", mem_req, 1);
    check("t2_addr", mem_addr, 32'h0000_1000);
    check("t2_wstrb", mem_wstrb, 4'b0100);
    check("t2_wdata", mem_wdata, 32'hDDDD_DDDD);
    check("t2_we", mem_we, 1);
    step();
    check("t2_core_en", core_en, 1);
    check("t2_we_commit", mem_we, 0);
    step();

    // LH at 0x2002
    pc_addr = 32'h8; fetch_word = 32'h0021_1083; opcode = 7'b0000011; fn3 = 3'b001;
    alu_out = 32'h0000_2002; load_word = 32'h8001_1234; run = 1'b1;
    step();
    step();
    run = 1'b0;
    step();
    check("t3_req", mem_req, 1);
    check("t3_we", mem_we, 0);
    check("t3_wstrb", mem_wstrb, 0);
    check("t3_addr", mem_addr, 32'h0000_2000);
    step();
    check("t3_lh", mem_out, 32'hFFFF_8001);
    check("t3_core_en", core_en, 1);
    step();

    // LHU at 0x2002
    fn3 = 3'b101; run = 1'b1;
    step();
    step();
    run = 1'b0;
    step();
    step();
    check("t3_lhu", mem_out, 32'h0000_8001);
    step();

    // LW misaligned at 0x3001
    pc_addr = 32'h10; fetch_word = 32'h0000_A103; fn3 = 3'b010; alu_out = 32'h0000_3001; run = 1'b1;
    step();
    step();
    run = 1'b0;
    step();
    check("t4_no_req", mem_req, 0);
    check("t4_no_we", mem_we, 0);
    step();
    check("t4_misalign", misalign_err, 1);
    check("t4_mem_out", mem_out, 0);
    check("t4_core_en", core_en, 1);
    step();
    check("t4_core_en_once", core_en, 0);
    check("t4_instret", instret, 5);
    check("t4_bus_err", bus_err, 0);

    // fetch timeout: memory never ready
    zero_wait = 1'b0; opcode = 7'h13; fn3 = 3'b000; pc_addr = 32'h14; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_req_hold", mem_req, 1);
    end
    step();
    check("t5_req_drop", mem_req, 0);
    check("t5_bus_err", bus_err, 1);
    check("t5_instr_nop", instruction, 32'h0000_0013);
    run = 1'b0;
    step();
    check("t5_core_en", core_en, 1);
    step();
    check("t5_instret", instret, 6);

    // reset while FETCH waits; late ready must be ignored
    pc_addr = 32'h18; run = 1'b1;
    step();
    step();
    step();
    check("t6_waiting", mem_req, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_req", mem_req, 0);
    check("t6_rst_addr", mem_addr, 0);
    check("t6_rst_instr", instruction, 32'h0000_0013);
    check("t6_rst_errs", {misalign_err, bus_err}, 0);
    check("t6_rst_instret", instret, 0);
    force_ready = 1'b1; fetch_word = 32'hDEAD_BEEF; run = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("t6_late_ready_instr", instruction, 32'h0000_0013);
    check("t6_late_ready_req", mem_req, 0);
    check("t6_late_ready_core_en", core_en, 0);
    force_ready = 1'b0; zero_wait = 1'b1; fetch_word = 32'h00A0_0113; run = 1'b1;
    step();
    check("t6_restart_req", mem_req, 1);
    check("t6_restart_addr", mem_addr, 32'h18);
    step();
    check("t6_restart_instr", instruction, 32'h00A0_0113);
    run = 1'b0;
    step();
    check("t6_restart_core_en", core_en, 1);
    step();
    check("t6_restart_instret", instret, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
